// File: rtl/dpram_rmw_port.sv
// dpram_rmw_port
//   Requester for one port of a dual-port RAM. It accepts word reads and
//   byte-masked writes over a valid/ready handshake. The RAM port has no byte
//   enables, so a partial write is done as read, merge, then write back.
//
//   Optional build macro: DPRAM_RMW_FWD_EN
//     When defined, a last-write register (valid, addr, data) is kept.
//     A read that hits it completes from the register without touching the RAM.
//     A partial write that hits it merges against the register and skips the
//     read. This is only safe when this block is the only writer of the RAM.
//
//   Ports
//     clk        : single clock
//     reset      : synchronous, active-high reset
//     req_valid  : request present
//     req_ready  : high in IDLE; a request is taken when valid && ready
//     req_write  : 1 = write, 0 = read
//     req_addr   : word address
//     req_wdata  : write data
//     req_be     : byte enables, bit i covers data[8i+7:8i]
//     rsp_valid  : one-cycle completion pulse per accepted request
//     rsp_rdata  : read -> RAM word, write -> merged word written, be==0 -> 0
//     ram_addr   : RAM address
//     ram_data   : RAM write data
//     ram_wren   : RAM write enable, high only in the WR state
//     ram_q      : RAM read data (registered, one-cycle latency)

module dpram_rmw_port #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   localparam int NB = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [NB-1:0]     req_be,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD   = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_WR   = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam logic [NB-1:0] BE_ALL = {NB{1'b1}};

   logic [2:0]        state_r;
   logic              write_r;
   logic [DATA_W-1:0] wdata_r;
   logic [NB-1:0]     be_r;
   logic [ADDR_W-1:0] ram_addr_r;
   logic [DATA_W-1:0] ram_data_r;
   logic              ram_wren_r;
   logic              rsp_valid_r;
   logic [DATA_W-1:0] rsp_rdata_r;

`ifdef DPRAM_RMW_FWD_EN
   logic              last_vld_r;
   logic [ADDR_W-1:0] last_addr_r;
   logic [DATA_W-1:0] last_data_r;
   logic [DATA_W-1:0] done_data_r;
   logic              hit_s;
`endif

   // Byte-lane merge: enabled lanes take the new data, others keep the old word.
   function automatic logic [DATA_W-1:0] merge_lanes(
      input logic [DATA_W-1:0] new_word,
      input logic [NB-1:0]     lane_en,
      input logic [DATA_W-1:0] old_word
   );
      logic [DATA_W-1:0] merged;
      merged = old_word;
      for (int i = 0; i < NB; i++) begin
         if (lane_en[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            merged[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

   assign req_ready = (state_r == ST_IDLE);
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign ram_addr  = ram_addr_r;
   assign ram_data  = ram_data_r;
   assign ram_wren  = ram_wren_r;

`ifdef DPRAM_RMW_FWD_EN
   assign hit_s = last_vld_r && (last_addr_r == req_addr);
`endif

   // Request sequencer: accept, optional RAM read, merge, write back, respond.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         write_r     <= 1'b0;
         wdata_r     <= '0;
         be_r        <= '0;
         ram_addr_r  <= '0;
         ram_data_r  <= '0;
         ram_wren_r  <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= '0;
`ifdef DPRAM_RMW_FWD_EN
         last_vld_r  <= 1'b0;
         last_addr_r <= '0;
         last_data_r <= '0;
         done_data_r <= '0;
`endif
      end else begin
         // Pulses: asserted only by the transition that needs them.
         rsp_valid_r <= 1'b0;
         ram_wren_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  ram_addr_r <= req_addr;
                  write_r    <= req_write;
                  wdata_r    <= req_wdata;
                  be_r       <= req_be;
`ifdef DPRAM_RMW_FWD_EN
                  if (!req_write && hit_s) begin
                     done_data_r <= last_data_r;
                     state_r     <= ST_DONE;
                  end else if (req_write && (req_be == '0)) begin
                     done_data_r <= '0;
                     state_r     <= ST_DONE;
                  end else if (req_write && (req_be == BE_ALL)) begin
                     ram_data_r <= req_wdata;
                     ram_wren_r <= 1'b1;
                     state_r    <= ST_WR;
                  end else if (req_write && hit_s) begin
                     // Cached copy is current because this block is the sole writer.
                     ram_data_r <= merge_lanes(req_wdata, req_be, last_data_r);
                     ram_wren_r <= 1'b1;
                     state_r    <= ST_WR;
                  end else begin
                     state_r <= ST_RD;
                  end
`else
                  if (req_write && (req_be == '0)) begin
                     state_r <= ST_DONE;
                  end else if (req_write && (req_be == BE_ALL)) begin
                     ram_data_r <= req_wdata;
                     ram_wren_r <= 1'b1;
                     state_r    <= ST_WR;
                  end else begin
                     state_r <= ST_RD;
                  end
`endif
               end
            end
            ST_RD: begin
               // RAM samples ram_addr at the end of this cycle.
               state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               if (write_r) begin
                  // Merge uses the word sampled now; a concurrent write from
                  // the other RAM port after this point is not seen.
                  ram_data_r <= merge_lanes(wdata_r, be_r, ram_q);
                  ram_wren_r <= 1'b1;
                  state_r    <= ST_WR;
               end else begin
                  rsp_rdata_r <= ram_q;
                  rsp_valid_r <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            ST_WR: begin
               rsp_rdata_r <= ram_data_r;
               rsp_valid_r <= 1'b1;
               state_r     <= ST_IDLE;
`ifdef DPRAM_RMW_FWD_EN
               last_vld_r  <= 1'b1;
               last_addr_r <= ram_addr_r;
               last_data_r <= ram_data_r;
`endif
            end
            ST_DONE: begin
`ifdef DPRAM_RMW_FWD_EN
               rsp_rdata_r <= done_data_r;
`else
               rsp_rdata_r <= '0;
`endif
               rsp_valid_r <= 1'b1;
               state_r     <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dpram_rmw_port.sv
// tb_dpram_rmw_port
//   Directed bench for dpram_rmw_port with a behavioural RAM port model
//   (registered q, old data on a same-edge write). Latencies for cache hits
//   depend on DPRAM_RMW_FWD_EN.

module tb_dpram_rmw_port;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [9:0]  ram_addr;
   logic [31:0] ram_data;
   logic        ram_wren;
   logic [31:0] ram_q;

   logic [31:0] mem [0:1023];

   int n_chk;
   int n_pass;
   logic [31:0] prev_rdata;

`ifdef DPRAM_RMW_FWD_EN
   localparam int HIT_RD_RSP  = 2;
   localparam int HIT_PW_RSP  = 2;
   localparam int HIT_PW_WREN = 1;
`else
   localparam int HIT_RD_RSP  = 3;
   localparam int HIT_PW_RSP  = 4;
   localparam int HIT_PW_WREN = 3;
`endif

   dpram_rmw_port #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_wren  (ram_wren),
      .ram_q     (ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM port model: registered read, read returns old data on a write edge.
   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
         $error("check %s got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] b2w(input logic b);
      return {31'd0, b};
   endfunction

   // Issue one request in the current cycle and follow it to its response.
   // rsp_c / wren_c: cycle after the accept edge where rsp_valid / ram_wren
   // must be high (wren_c == 0 means never).
   task automatic do_req(input string tag, input logic wr, input logic [9:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         input int rsp_c, input int wren_c, input logic [31:0] exp_rd);
      chk({tag, "/ready_in"}, b2w(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      req_be    = be;
      tick();
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 10'd0;
      req_wdata = 32'd0;
      req_be    = 4'd0;
      for (int c = 1; c <= rsp_c; c++) begin
         chk($sformatf("%s/rsp_valid@%0d", tag, c), b2w(rsp_valid), (c == rsp_c) ? 32'd1 : 32'd0);
         chk($sformatf("%s/ram_wren@%0d", tag, c), b2w(ram_wren), (c == wren_c) ? 32'd1 : 32'd0);
         chk($sformatf("%s/ram_addr@%0d", tag, c), {22'd0, ram_addr}, {22'd0, a});
         if (c == wren_c) chk({tag, "/ram_data"}, ram_data, exp_rd);
         if (c == 1) chk({tag, "/rdata_hold"}, rsp_rdata, prev_rdata);
         if (c < rsp_c) begin
            chk($sformatf("%s/ready@%0d", tag, c), b2w(req_ready), 32'd0);
            tick();
         end
      end
      chk({tag, "/rsp_rdata"}, rsp_rdata, exp_rd);
      chk({tag, "/ready_out"}, b2w(req_ready), 32'd1);
      prev_rdata = exp_rd;
   endtask

   initial begin
      n_chk      = 0;
      n_pass     = 0;
      prev_rdata = 32'd0;

      // Reset held with a request present: nothing may happen.
      reset     = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 10'h003;
      req_wdata = 32'h12345678;
      req_be    = 4'hF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst/ram_wren", b2w(ram_wren), 32'd0);
         chk("rst/rsp_valid", b2w(rsp_valid), 32'd0);
      end
      reset     = 1'b0;
      req_valid = 1'b0;
      tick();
      chk("idle/ready", b2w(req_ready), 32'd1);
      chk("idle/ram_wren", b2w(ram_wren), 32'd0);
      chk("idle/rsp_valid", b2w(rsp_valid), 32'd0);
      chk("idle/ram_addr", {22'd0, ram_addr}, 32'd0);
      chk("idle/ram_data", ram_data, 32'd0);
      chk("idle/rsp_rdata", rsp_rdata, 32'd0);

      // Preload two words through full writes.
      do_req("wr8", 1'b1, 10'h008, 32'h0BADF00D, 4'hF, 2, 1, 32'h0BADF00D);
      do_req("wr6", 1'b1, 10'h006, 32'h01020304, 4'hF, 2, 1, 32'h01020304);

      // Full write then read back.
      do_req("wr5", 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 2, 1, 32'hDEADBEEF);
      chk("wr5/mem", mem[5], 32'hDEADBEEF);
      do_req("rd5", 1'b0, 10'h005, 32'd0, 4'h0, HIT_RD_RSP, 0, 32'hDEADBEEF);

      // Partial write lanes 0 and 2 over DEADBEEF.
      do_req("pw5", 1'b1, 10'h005, 32'h11223344, 4'h5, HIT_PW_RSP, HIT_PW_WREN, 32'hDE22BE44);
      chk("pw5/mem", mem[5], 32'hDE22BE44);

      // Write with no enables: 2-cycle, no RAM write.
      do_req("be0", 1'b1, 10'h005, 32'hFFFFFFFF, 4'h0, 2, 0, 32'd0);
      chk("be0/mem", mem[5], 32'hDE22BE44);

      // Reset during WAIT of a partial write to 0x006.
      chk("abort/ready_in", b2w(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 10'h006;
      req_wdata = 32'hFFFFFFFF;
      req_be    = 4'h3;
      tick();
      req_valid = 1'b0;
      chk("abort/rsp_valid_1", b2w(rsp_valid), 32'd0);
      chk("abort/ram_wren_1", b2w(ram_wren), 32'd0);
      tick();
      chk("abort/ram_wren_2", b2w(ram_wren), 32'd0);
      chk("abort/ready_2", b2w(req_ready), 32'd0);
      reset = 1'b1;
      tick();
      chk("abort/ram_wren_r", b2w(ram_wren), 32'd0);
      chk("abort/rsp_valid_r", b2w(rsp_valid), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort/ram_wren_post", b2w(ram_wren), 32'd0);
         chk("abort/rsp_valid_post", b2w(rsp_valid), 32'd0);
      end
      chk("abort/ready", b2w(req_ready), 32'd1);
      chk("abort/mem6", mem[6], 32'h01020304);
      chk("abort/ram_addr", {22'd0, ram_addr}, 32'd0);
      prev_rdata = 32'd0;

      // Reset clears any cached write, so this read goes through the RAM.
      do_req("rd5_post", 1'b0, 10'h005, 32'd0, 4'h0, 3, 0, 32'hDE22BE44);
      do_req("rd6_post", 1'b0, 10'h006, 32'd0, 4'h0, 3, 0, 32'h01020304);

      // Forwarding scenario: write then read same address; other address misses.
      do_req("wr7", 1'b1, 10'h007, 32'hA5A5A5A5, 4'hF, 2, 1, 32'hA5A5A5A5);
      do_req("rd7", 1'b0, 10'h007, 32'd0, 4'h0, HIT_RD_RSP, 0, 32'hA5A5A5A5);
      do_req("rd8", 1'b0, 10'h008, 32'd0, 4'h0, 3, 0, 32'h0BADF00D);

      tick();
      chk("end/rsp_valid", b2w(rsp_valid), 32'd0);
      chk("end/rdata_hold", rsp_rdata, 32'h0BADF00D);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
